// File: rtl/radial_gain_corrector.sv
// radial_gain_corrector
// Lens-shading style radial gain correction on a streaming pixel bus.
// Each pixel's squared distance from a programmable lens centre is scaled
// by a right shift and turned into a Q8.8 gain (attenuate towards a floor,
// boost towards a ceiling, or unity in bypass). Every channel is multiplied
// by that gain and clamped. Fixed 5-cycle latency, no back-pressure.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   vsync_i, valid_i      end-of-frame pulse and pixel strobe
//   pix_i                 NUM_CH packed channels, channel 0 in the LSBs
//   h_cnt, v_cnt          pixel coordinates
//   cfg_wr                writes all cfg_* fields into the shadow registers
//   cfg_mode              00 bypass, 01 attenuate, 10 boost, 11 bypass
//   cfg_cx, cfg_cy        lens centre
//   cfg_kshift            radial shift
//   cfg_min_gain          Q8.8 floor used by attenuate
//   vsync_o, valid_o      5-cycle delayed copies of vsync_i / valid_i
//   pix_o                 corrected pixel, zero whenever valid_o is low
//   cfg_pending_o         shadow holds a write not yet applied at vsync
module radial_gain_corrector #(
    parameter int          DATA_WIDTH = 8,
    parameter int          NUM_CH     = 3,
    parameter int          CNT_WIDTH  = 11,
    parameter logic [15:0] GAIN_MAX   = 16'd1023
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vsync_i,
    input  logic                           valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   pix_i,
    input  logic [CNT_WIDTH-1:0]           h_cnt,
    input  logic [CNT_WIDTH-1:0]           v_cnt,
    input  logic                           cfg_wr,
    input  logic [1:0]                     cfg_mode,
    input  logic [CNT_WIDTH-1:0]           cfg_cx,
    input  logic [CNT_WIDTH-1:0]           cfg_cy,
    input  logic [4:0]                     cfg_kshift,
    input  logic [15:0]                    cfg_min_gain,
    output logic                           vsync_o,
    output logic                           valid_o,
    output logic [NUM_CH*DATA_WIDTH-1:0]   pix_o,
    output logic                           cfg_pending_o
);
    localparam int PW   = NUM_CH * DATA_WIDTH;
    localparam int DXW  = CNT_WIDTH + 1;   // signed coordinate difference
    localparam int SQW  = 2 * DXW;         // square of a difference
    localparam int SUMW = SQW + 1;         // sum of two squares
    localparam int SW   = SUMW + 2;        // headroom for signed gain maths
    localparam int GW   = 16;              // Q8.8 gain
    localparam int PRW  = DATA_WIDTH + GW; // channel * gain

    localparam logic [CNT_WIDTH-1:0] RST_CX  = CNT_WIDTH'(640);
    localparam logic [CNT_WIDTH-1:0] RST_CY  = CNT_WIDTH'(360);
    localparam logic [4:0]           RST_KSH = 5'd12;
    localparam logic [GW-1:0]        UNITY   = 16'd256;
    localparam logic signed [SW-1:0] UNITY_S = SW'(256);

    // Shadow and active configuration
    logic [1:0]           sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [CNT_WIDTH-1:0] sh_cx_q, sh_cx_d, act_cx_q, act_cx_d;
    logic [CNT_WIDTH-1:0] sh_cy_q, sh_cy_d, act_cy_q, act_cy_d;
    logic [4:0]           sh_ksh_q, sh_ksh_d, act_ksh_q, act_ksh_d;
    logic [GW-1:0]        sh_min_q, sh_min_d, act_min_q, act_min_d;
    logic                 pending_q, pending_d;

    // Pipeline; each stage carries the configuration it still needs
    logic                  s1_valid_q, s1_valid_d, s1_vsync_q, s1_vsync_d;
    logic [PW-1:0]         s1_pix_q, s1_pix_d;
    logic signed [DXW-1:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic [4:0]            s1_ksh_q, s1_ksh_d;
    logic [GW-1:0]         s1_min_q, s1_min_d;

    logic                  s2_valid_q, s2_valid_d, s2_vsync_q, s2_vsync_d;
    logic [PW-1:0]         s2_pix_q, s2_pix_d;
    logic [SQW-1:0]        s2_sqx_q, s2_sqx_d, s2_sqy_q, s2_sqy_d;
    logic [1:0]            s2_mode_q, s2_mode_d;
    logic [4:0]            s2_ksh_q, s2_ksh_d;
    logic [GW-1:0]         s2_min_q, s2_min_d;

    logic                  s3_valid_q, s3_valid_d, s3_vsync_q, s3_vsync_d;
    logic [PW-1:0]         s3_pix_q, s3_pix_d;
    logic [SUMW-1:0]       s3_term_q, s3_term_d;
    logic [1:0]            s3_mode_q, s3_mode_d;
    logic [GW-1:0]         s3_min_q, s3_min_d;

    logic                  s4_valid_q, s4_valid_d, s4_vsync_q, s4_vsync_d;
    logic [PW-1:0]         s4_pix_q, s4_pix_d;
    logic [GW-1:0]         s4_gain_q, s4_gain_d;

    logic                  valid_o_q, valid_o_d, vsync_o_q, vsync_o_d;
    logic [PW-1:0]         pix_o_q, pix_o_d;

    // Combinational helpers
    logic signed [SQW-1:0] dx_ext, dy_ext;
    logic [SUMW-1:0]       sq_sum;
    logic signed [SW-1:0]  att_s, min_s;
    logic [SW-1:0]         boost_sum, gmax_ext;
    logic [PW-1:0]         ch_scaled;

    // Per-channel multiply, truncate and saturate
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] ch;
            logic [PRW-1:0]        prod;
            logic [PRW-9:0]        shifted;
            assign ch      = s4_pix_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign prod    = {{GW{1'b0}}, ch} * {{DATA_WIDTH{1'b0}}, s4_gain_q};
            assign shifted = prod[PRW-1:8];
            assign ch_scaled[gi*DATA_WIDTH +: DATA_WIDTH] =
                (shifted > {{(PRW-8-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}})
                    ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        // Shadow capture; the active copy follows the shadow's next value so
        // a write coinciding with vsync_i takes effect straight away.
        sh_mode_d = sh_mode_q; sh_cx_d = sh_cx_q; sh_cy_d = sh_cy_q;
        sh_ksh_d  = sh_ksh_q;  sh_min_d = sh_min_q;
        if (cfg_wr) begin
            sh_mode_d = cfg_mode; sh_cx_d = cfg_cx; sh_cy_d = cfg_cy;
            sh_ksh_d  = cfg_kshift; sh_min_d = cfg_min_gain;
        end
        act_mode_d = act_mode_q; act_cx_d = act_cx_q; act_cy_d = act_cy_q;
        act_ksh_d  = act_ksh_q;  act_min_d = act_min_q;
        if (vsync_i) begin
            act_mode_d = sh_mode_d; act_cx_d = sh_cx_d; act_cy_d = sh_cy_d;
            act_ksh_d  = sh_ksh_d;  act_min_d = sh_min_d;
        end
        pending_d = pending_q;
        if (cfg_wr)  pending_d = 1'b1;
        if (vsync_i) pending_d = 1'b0;

        // S1: offsets from centre, snapshot of the active configuration
        s1_valid_d = valid_i;
        s1_vsync_d = vsync_i;
        s1_pix_d   = pix_i;
        s1_dx_d    = $signed({1'b0, h_cnt}) - $signed({1'b0, act_cx_q});
        s1_dy_d    = $signed({1'b0, v_cnt}) - $signed({1'b0, act_cy_q});
        s1_mode_d  = act_mode_q;
        s1_ksh_d   = act_ksh_q;
        s1_min_d   = act_min_q;

        // S2: squares (always non-negative, so stored unsigned)
        dx_ext     = {{DXW{s1_dx_q[DXW-1]}}, s1_dx_q};
        dy_ext     = {{DXW{s1_dy_q[DXW-1]}}, s1_dy_q};
        s2_sqx_d   = dx_ext * dx_ext;
        s2_sqy_d   = dy_ext * dy_ext;
        s2_valid_d = s1_valid_q; s2_vsync_d = s1_vsync_q; s2_pix_d = s1_pix_q;
        s2_mode_d  = s1_mode_q;  s2_ksh_d   = s1_ksh_q;   s2_min_d = s1_min_q;

        // S3: radial term
        sq_sum     = {1'b0, s2_sqx_q} + {1'b0, s2_sqy_q};
        s3_term_d  = sq_sum >> s2_ksh_q;
        s3_valid_d = s2_valid_q; s3_vsync_d = s2_vsync_q; s3_pix_d = s2_pix_q;
        s3_mode_d  = s2_mode_q;  s3_min_d   = s2_min_q;

        // S4: gain select. Attenuate goes negative for large terms, so it is
        // evaluated wide and signed before comparing against the floor.
        att_s     = UNITY_S - $signed({2'b00, s3_term_q});
        min_s     = $signed({{(SW-GW){1'b0}}, s3_min_q});
        boost_sum = {2'b00, s3_term_q} + SW'(256);
        gmax_ext  = {{(SW-GW){1'b0}}, GAIN_MAX};
        case (s3_mode_q)
            2'b01:   s4_gain_d = (att_s > min_s) ? att_s[GW-1:0] : s3_min_q;
            2'b10:   s4_gain_d = (boost_sum > gmax_ext) ? GAIN_MAX : boost_sum[GW-1:0];
            default: s4_gain_d = UNITY;
        endcase
        s4_valid_d = s3_valid_q; s4_vsync_d = s3_vsync_q; s4_pix_d = s3_pix_q;

        // S5: outputs; pixel forced to zero when not valid
        valid_o_d = s4_valid_q;
        vsync_o_d = s4_vsync_q;
        pix_o_d   = s4_valid_q ? ch_scaled : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode_q  <= 2'b00;  sh_cx_q  <= RST_CX; sh_cy_q  <= RST_CY;
            sh_ksh_q   <= RST_KSH; sh_min_q <= '0;
            act_mode_q <= 2'b00;  act_cx_q <= RST_CX; act_cy_q <= RST_CY;
            act_ksh_q  <= RST_KSH; act_min_q <= '0;
            pending_q  <= 1'b0;
            s1_valid_q <= 1'b0; s1_vsync_q <= 1'b0; s1_pix_q <= '0;
            s1_dx_q    <= '0;   s1_dy_q    <= '0;
            s1_mode_q  <= '0;   s1_ksh_q   <= '0;   s1_min_q <= '0;
            s2_valid_q <= 1'b0; s2_vsync_q <= 1'b0; s2_pix_q <= '0;
            s2_sqx_q   <= '0;   s2_sqy_q   <= '0;
            s2_mode_q  <= '0;   s2_ksh_q   <= '0;   s2_min_q <= '0;
            s3_valid_q <= 1'b0; s3_vsync_q <= 1'b0; s3_pix_q <= '0;
            s3_term_q  <= '0;   s3_mode_q  <= '0;   s3_min_q <= '0;
            s4_valid_q <= 1'b0; s4_vsync_q <= 1'b0; s4_pix_q <= '0;
            s4_gain_q  <= '0;
            valid_o_q  <= 1'b0; vsync_o_q  <= 1'b0; pix_o_q  <= '0;
        end else begin
            sh_mode_q  <= sh_mode_d;  sh_cx_q  <= sh_cx_d;  sh_cy_q  <= sh_cy_d;
            sh_ksh_q   <= sh_ksh_d;   sh_min_q <= sh_min_d;
            act_mode_q <= act_mode_d; act_cx_q <= act_cx_d; act_cy_q <= act_cy_d;
            act_ksh_q  <= act_ksh_d;  act_min_q <= act_min_d;
            pending_q  <= pending_d;
            s1_valid_q <= s1_valid_d; s1_vsync_q <= s1_vsync_d; s1_pix_q <= s1_pix_d;
            s1_dx_q    <= s1_dx_d;    s1_dy_q    <= s1_dy_d;
            s1_mode_q  <= s1_mode_d;  s1_ksh_q   <= s1_ksh_d;   s1_min_q <= s1_min_d;
            s2_valid_q <= s2_valid_d; s2_vsync_q <= s2_vsync_d; s2_pix_q <= s2_pix_d;
            s2_sqx_q   <= s2_sqx_d;   s2_sqy_q   <= s2_sqy_d;
            s2_mode_q  <= s2_mode_d;  s2_ksh_q   <= s2_ksh_d;   s2_min_q <= s2_min_d;
            s3_valid_q <= s3_valid_d; s3_vsync_q <= s3_vsync_d; s3_pix_q <= s3_pix_d;
            s3_term_q  <= s3_term_d;  s3_mode_q  <= s3_mode_d;  s3_min_q <= s3_min_d;
            s4_valid_q <= s4_valid_d; s4_vsync_q <= s4_vsync_d; s4_pix_q <= s4_pix_d;
            s4_gain_q  <= s4_gain_d;
            valid_o_q  <= valid_o_d;  vsync_o_q  <= vsync_o_d;  pix_o_q  <= pix_o_d;
        end
    end

    assign valid_o       = valid_o_q;
    assign vsync_o       = vsync_o_q;
    assign pix_o         = pix_o_q;
    assign cfg_pending_o = pending_q;

endmodule

// File: tb/tb_radial_gain_corrector.sv
// Self-checking bench for radial_gain_corrector: directed vector table plus
// hand-written sequences for config timing, bypass streams and reset.
module tb_radial_gain_corrector;
    localparam int DW = 8;
    localparam int NCH = 3;
    localparam int CW = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vsync_i, valid_i, cfg_wr;
    logic [NCH*DW-1:0] pix_i;
    logic [CW-1:0]   h_cnt, v_cnt, cfg_cx, cfg_cy;
    logic [1:0]      cfg_mode;
    logic [4:0]      cfg_kshift;
    logic [15:0]     cfg_min_gain;
    logic            vsync_o, valid_o, cfg_pending_o;
    logic [NCH*DW-1:0] pix_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    radial_gain_corrector dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync_i), .valid_i(valid_i),
        .pix_i(pix_i), .h_cnt(h_cnt), .v_cnt(v_cnt), .cfg_wr(cfg_wr),
        .cfg_mode(cfg_mode), .cfg_cx(cfg_cx), .cfg_cy(cfg_cy),
        .cfg_kshift(cfg_kshift), .cfg_min_gain(cfg_min_gain),
        .vsync_o(vsync_o), .valid_o(valid_o), .pix_o(pix_o),
        .cfg_pending_o(cfg_pending_o)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  ksh;
        logic [15:0] ming;
        logic [10:0] h, v;
        logic [7:0]  c0, c1, c2;
        logic [7:0]  e0, e1, e2;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input logic v, input logic [10:0] h, input logic [10:0] vc,
                             input logic [23:0] p, input logic vs);
        valid_i = v; h_cnt = h; v_cnt = vc; pix_i = p; vsync_i = vs;
    endtask

    task automatic set_cfg(input logic wr, input logic [1:0] m, input logic [4:0] k,
                           input logic [15:0] mg);
        cfg_wr = wr; cfg_mode = m; cfg_cx = 11'd640; cfg_cy = 11'd360;
        cfg_kshift = k; cfg_min_gain = mg;
    endtask

    // Write then apply at a separate vsync, checking the pending flag
    task automatic apply_cfg(input logic [1:0] m, input logic [4:0] k, input logic [15:0] mg);
        set_cfg(1'b1, m, k, mg);
        step();
        cfg_wr = 1'b0;
        check("pending_set", {31'd0, cfg_pending_o}, 32'd1);
        vsync_i = 1'b1;
        step();
        vsync_i = 1'b0;
        check("pending_clr", {31'd0, cfg_pending_o}, 32'd0);
    endtask

    task automatic run_stream(input logic [1:0] m, input int n);
        logic [23:0] hp[64];
        logic        hv[64];
        logic        hs[64];
        apply_cfg(m, 5'd12, 16'd0);
        for (int c = 0; c < n + 5; c++) begin
            if (c < n) begin
                hv[c] = ($urandom_range(0, 3) != 0);
                hs[c] = ($urandom_range(0, 7) == 0);
                hp[c] = 24'($urandom);
                drive_pix(hv[c], 11'($urandom), 11'($urandom), hp[c], hs[c]);
            end else begin
                drive_pix(1'b0, 11'd0, 11'd0, 24'd0, 1'b0);
            end
            step();
            if (c >= 4) begin
                check("stream_valid", {31'd0, valid_o}, {31'd0, hv[c-4]});
                check("stream_vsync", {31'd0, vsync_o}, {31'd0, hs[c-4]});
                check("stream_pix", {8'd0, pix_o}, {8'd0, hv[c-4] ? hp[c-4] : 24'd0});
            end
        end
    endtask

    initial begin
        logic [7:0] mexp[6];
        logic       mwr[6], mvs[6], mpend[6];

        vecs[0]  = '{2'b01, 5'd12, 16'd0,   11'd0,   11'd0,   8'd200, 8'd200, 8'd200, 8'd97,  8'd97,  8'd97};
        vecs[1]  = '{2'b10, 5'd12, 16'd0,   11'd0,   11'd0,   8'd200, 8'd200, 8'd200, 8'd255, 8'd255, 8'd255};
        vecs[2]  = '{2'b01, 5'd10, 16'd32,  11'd0,   11'd0,   8'd200, 8'd200, 8'd200, 8'd25,  8'd25,  8'd25};
        vecs[3]  = '{2'b01, 5'd10, 16'd32,  11'd640, 11'd360, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        vecs[4]  = '{2'b11, 5'd10, 16'd0,   11'd0,   11'd0,   8'd200, 8'd17,  8'd255, 8'd200, 8'd17,  8'd255};
        vecs[5]  = '{2'b01, 5'd12, 16'd0,   11'd0,   11'd0,   8'd200, 8'd100, 8'd3,   8'd97,  8'd48,  8'd1};
        vecs[6]  = '{2'b10, 5'd10, 16'd0,   11'd0,   11'd0,   8'd50,  8'd50,  8'd50,  8'd152, 8'd152, 8'd152};
        vecs[7]  = '{2'b10, 5'd0,  16'd0,   11'd0,   11'd0,   8'd10,  8'd10,  8'd10,  8'd39,  8'd39,  8'd39};
        vecs[8]  = '{2'b01, 5'd0,  16'd0,   11'd0,   11'd0,   8'd200, 8'd200, 8'd200, 8'd0,   8'd0,   8'd0};
        vecs[9]  = '{2'b01, 5'd12, 16'd300, 11'd0,   11'd0,   8'd100, 8'd100, 8'd100, 8'd117, 8'd117, 8'd117};
        vecs[10] = '{2'b01, 5'd31, 16'd0,   11'd2047,11'd2047,8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
        vecs[11] = '{2'b10, 5'd4,  16'd0,   11'd650, 11'd360, 8'd100, 8'd100, 8'd100, 8'd102, 8'd102, 8'd102};
        vecs[12] = '{2'b01, 5'd4,  16'd0,   11'd640, 11'd376, 8'd100, 8'd100, 8'd100, 8'd93,  8'd93,  8'd93};

        rst_n = 1'b0;
        set_cfg(1'b0, 2'b00, 5'd0, 16'd0);
        drive_pix(1'b0, 11'd0, 11'd0, 24'd0, 1'b0);
        step();
        step();
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_vsync", {31'd0, vsync_o}, 32'd0);
        check("rst_pix", {8'd0, pix_o}, 32'd0);
        check("rst_pending", {31'd0, cfg_pending_o}, 32'd0);
        rst_n = 1'b1;
        step();

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            apply_cfg(vecs[i].mode, vecs[i].ksh, vecs[i].ming);
            drive_pix(1'b1, vecs[i].h, vecs[i].v, {vecs[i].c2, vecs[i].c1, vecs[i].c0}, 1'b0);
            step();
            valid_i = 1'b0;
            for (int k = 0; k < 4; k++) step();
            check($sformatf("vec%0d_valid", i), {31'd0, valid_o}, 32'd1);
            check($sformatf("vec%0d_ch0", i), {24'd0, pix_o[7:0]},   {24'd0, vecs[i].e0});
            check($sformatf("vec%0d_ch1", i), {24'd0, pix_o[15:8]},  {24'd0, vecs[i].e1});
            check($sformatf("vec%0d_ch2", i), {24'd0, pix_o[23:16]}, {24'd0, vecs[i].e2});
            step();
            check($sformatf("vec%0d_idle", i), {7'd0, valid_o, pix_o}, 32'd0);
        end

        // Mid-frame write: old mode until the pixel after vsync_i
        apply_cfg(2'b01, 5'd12, 16'd0);
        mwr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        mvs   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        mpend = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        mexp  = '{8'd97, 8'd97, 8'd97, 8'd97, 8'd255, 8'd255};
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin
                set_cfg(mwr[c], 2'b10, 5'd12, 16'd0);
                drive_pix(1'b1, 11'd0, 11'd0, {3{8'd200}}, mvs[c]);
            end else begin
                set_cfg(1'b0, 2'b10, 5'd12, 16'd0);
                drive_pix(1'b0, 11'd0, 11'd0, 24'd0, 1'b0);
            end
            step();
            if (c < 6) check($sformatf("mid_pending%0d", c), {31'd0, cfg_pending_o}, {31'd0, mpend[c]});
            if (c >= 4) check($sformatf("mid_pix%0d", c - 4), {8'd0, pix_o}, {8'd0, {3{mexp[c-4]}}});
        end

        // Write coincident with vsync_i: applies to the next pixel, no pending
        for (int c = 0; c < 6; c++) begin
            set_cfg(c == 0, 2'b01, 5'd12, 16'd0);
            drive_pix(c < 2, 11'd0, 11'd0, {3{8'd200}}, c == 0);
            step();
            check($sformatf("coin_pending%0d", c), {31'd0, cfg_pending_o}, 32'd0);
            if (c == 4) check("coin_pix0", {8'd0, pix_o}, {8'd0, {3{8'd255}}});
            if (c == 5) check("coin_pix1", {8'd0, pix_o}, {8'd0, {3{8'd97}}});
        end
        cfg_wr = 1'b0;

        // Bypass streams (mode 00 and 11)
        run_stream(2'b00, 40);
        run_stream(2'b11, 40);

        // Reset mid-stream
        apply_cfg(2'b10, 5'd12, 16'd0);
        for (int c = 0; c < 6; c++) begin
            set_cfg(c == 5, 2'b01, 5'd12, 16'd0);
            drive_pix(1'b1, 11'd0, 11'd0, {3{8'd200}}, 1'b0);
            step();
        end
        cfg_wr = 1'b0;
        check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        check("pre_rst_pending", {31'd0, cfg_pending_o}, 32'd1);
        rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, valid_o}, 32'd0);
        check("async_rst_pix", {8'd0, pix_o}, 32'd0);
        check("async_rst_pending", {31'd0, cfg_pending_o}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("no_stale_valid", {31'd0, valid_o}, 32'd0);
        end
        drive_pix(1'b1, 11'd0, 11'd0, {3{8'd200}}, 1'b0);
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_latency", {31'd0, valid_o}, 32'd0);
        end
        step();
        check("post_rst_valid", {31'd0, valid_o}, 32'd1);
        check("post_rst_active_default", {8'd0, pix_o}, {8'd0, {3{8'd200}}});
        // Shadow must also be back to defaults: applying it keeps bypass
        vsync_i = 1'b1;
        step();
        vsync_i = 1'b0;
        drive_pix(1'b1, 11'd0, 11'd0, {3{8'd200}}, 1'b0);
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("post_rst_shadow_default", {8'd0, pix_o}, {8'd0, {3{8'd200}}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/radial_gain_corrector.md
RADIAL_GAIN_CORRECTOR -- requirements
Module: radial_gain_corrector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per colour channel.
REQ-002 SHALL have parameter NUM_CH, default 3, number of colour channels packed in one pixel word.
REQ-003 SHALL have parameter CNT_WIDTH, default 11, width of h_cnt/v_cnt and of the centre coordinates.
REQ-004 SHALL have parameter GAIN_MAX, default 16'd1023, upper gain clamp in Q8.8 format.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port vsync_i, input, 1, end-of-frame pulse.
REQ-008 SHALL have port valid_i, input, 1, pixel-valid strobe.
REQ-009 SHALL have port pix_i, input, NUM_CH*DATA_WIDTH, packed pixel with channel 0 in the LSBs.
REQ-010 SHALL have ports h_cnt and v_cnt, input, CNT_WIDTH each, pixel coordinates.
REQ-011 SHALL have port cfg_wr, input, 1, one-cycle strobe that writes the shadow configuration.
REQ-012 SHALL have port cfg_mode, input, 2: 00 bypass, 01 attenuate, 10 boost, 11 treated as bypass.
REQ-013 SHALL have ports cfg_cx and cfg_cy, input, CNT_WIDTH each, the lens centre.
REQ-014 SHALL have port cfg_kshift, input, 5, radial shift (valid range 0-31).
REQ-015 SHALL have port cfg_min_gain, input, 16, Q8.8 gain floor used in attenuate mode.
REQ-016 SHALL have ports vsync_o and valid_o, output, 1 each, delayed copies of vsync_i and valid_i.
REQ-017 SHALL have port pix_o, output, NUM_CH*DATA_WIDTH, corrected pixel.
REQ-018 SHALL have port cfg_pending_o, output, 1, high while the shadow configuration differs from the active configuration because of an un-applied write.

Function
REQ-019 SHALL capture all cfg_* inputs into shadow registers on any cycle with cfg_wr=1.
REQ-020 SHALL copy shadow to active configuration on any cycle with vsync_i=1; the datapath SHALL use only the active configuration.
REQ-021 SHALL, when cfg_wr and vsync_i are both 1 in the same cycle, load active with the values written that cycle and clear cfg_pending_o.
REQ-022 SHALL set cfg_pending_o the cycle after cfg_wr and clear it the cycle after vsync_i.
REQ-023 SHALL have a 5-stage pipeline: S1 dx=h_cnt-cx and dy=v_cnt-cy, signed CNT_WIDTH+1 bits; S2 dx^2 and dy^2; S3 term=(dx^2+dy^2)>>kshift; S4 gain select; S5 multiply and clamp, registered to the outputs.
REQ-024 SHALL give fixed latency for valid_o, vsync_o and pix_o of 5 clk cycles relative to the inputs, in every mode.
REQ-025 SHALL latch the active configuration per pixel at S1 and carry it down the pipeline, so an update at vsync_i never splits a pixel's computation.
REQ-026 SHALL, in bypass mode, use gain = 256.
REQ-027 SHALL, in attenuate mode, use gain = max(256 - term, cfg_min_gain), computed in signed arithmetic; a negative intermediate SHALL never wrap.
REQ-028 SHALL, in boost mode, use gain = min(256 + term, GAIN_MAX), with no overflow of the sum.
REQ-029 SHALL, for each channel, compute out = (ch * gain) >> 8, truncated, then clamp to 2^DATA_WIDTH-1.
REQ-030 SHALL advance the pipeline every cycle regardless of valid_i, with no back-pressure.
REQ-031 SHALL drive pix_o = 0 whenever valid_o = 0.

Reset
REQ-032 SHALL, while rst_n=0, immediately clear all pipeline registers, vsync_o, valid_o, pix_o and cfg_pending_o.
REQ-033 SHALL reset shadow and active configuration to: mode 00, cx = 640, cy = 360, kshift = 12, min_gain = 0.
REQ-034 SHALL discard any in-flight pixels on reset mid-frame; valid_o SHALL stay 0 until 5 cycles after the first valid_i following reset release.

Verification
REQ-035 SHALL be covered by a bench scenario: reset defaults, apply cfg mode 01 and one vsync_i, then pixel (0,0) with all channels 200 -> 5 cycles later every channel is 97 (term = 539200>>12 = 131, gain = 125).
REQ-036 SHALL be covered by a bench scenario: mode 10, same pixel -> gain 387, 200*387>>8 = 302 -> every channel 255.
REQ-037 SHALL be covered by a bench scenario: mode 01, kshift 10, min_gain 32, pixel (0,0) value 200 -> term 526, floor applies -> every channel 25; pixel (640,360) -> 200.
REQ-038 SHALL be covered by a bench scenario: mid-frame cfg_wr to mode 10 -> output unchanged and cfg_pending_o=1 until the pixel entering the cycle after vsync_i; cfg_wr coincident with vsync_i -> new mode applies immediately and cfg_pending_o stays 0.
REQ-039 SHALL be covered by a bench scenario: mode 00 or 11 with random pixels -> pix_o equals pix_i delayed exactly 5 cycles; valid_i=0 -> pix_o=0.
REQ-040 SHALL be covered by a bench scenario: assert rst_n=0 for 1 cycle mid-stream -> outputs 0 within the same cycle, configuration returns to the REQ-033 defaults, and no stale valid_o pulse appears.
